// File: rtl/wb_retire_buffer.sv
// Write-back retire buffer: per-lane result select, in-order circular queue, single registered RF write port.
// Optional operand forwarding lookup is built when WB_FWD_EN is defined.
module wb_retire_buffer #(
    parameter  int XLEN    = 64,
    parameter  int NUM_SRC = 2,
    parameter  int DEPTH   = 4,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SRC-1:0]      in_valid,
    output logic                    in_ready,
    input  logic [NUM_SRC*7-1:0]    in_opcode,
    input  logic [NUM_SRC*5-1:0]    in_rd,
    input  logic [NUM_SRC*XLEN-1:0] in_alu_result,
    input  logic [NUM_SRC*XLEN-1:0] in_load_data,
    input  logic [NUM_SRC*XLEN-1:0] in_pc,
    input  logic                    wr_stall,
    output logic                    wr_en,
    output logic [4:0]              wr_reg,
    output logic [XLEN-1:0]         wr_data,
    output logic [CW-1:0]           count,
    output logic [31:0]             pending_mask,
    input  logic [4:0]              fwd_rs,
    output logic                    fwd_hit,
    output logic [XLEN-1:0]         fwd_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {SEL_NONE, SEL_ALU, SEL_LOAD, SEL_PC} sel_e;

    function automatic sel_e decode(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0111011, 7'b0010011,
            7'b0011011, 7'b0010111:              decode = SEL_ALU;
            7'b0000011, 7'b0110111:              decode = SEL_LOAD;
            7'b1101111, 7'b1100111:              decode = SEL_PC;
            default:                             decode = SEL_NONE;
        endcase
    endfunction

    logic [4:0]      buf_rd   [DEPTH];
    logic [XLEN-1:0] buf_data [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;

    logic [NUM_SRC-1:0] lane_wr;
    logic [XLEN-1:0]    lane_data [NUM_SRC];
    logic [PW-1:0]      lane_slot [NUM_SRC];
    logic [CW-1:0]      n_writers;
    logic               pop;
    logic               accept;

    assign in_ready = (count <= CW'(DEPTH - NUM_SRC));
    assign accept   = in_ready;
    assign pop      = (count != '0) && !wr_stall;

    // Writers are packed densely after the tail, so each lane's slot skips earlier non-writers.
    always_comb begin
        int   running;
        sel_e sel;
        running   = 0;
        lane_wr   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel          = decode(in_opcode[7*i +: 7]);
            lane_data[i] = '0;
            case (sel)
                SEL_ALU:  lane_data[i] = in_alu_result[XLEN*i +: XLEN];
                SEL_LOAD: lane_data[i] = in_load_data[XLEN*i +: XLEN];
                SEL_PC:   lane_data[i] = in_pc[XLEN*i +: XLEN];
                default:  lane_data[i] = '0;
            endcase
            lane_wr[i]   = in_valid[i] && (sel != SEL_NONE) && (in_rd[5*i +: 5] != 5'd0);
            lane_slot[i] = PW'((int'(tail) + running) % DEPTH);
            if (lane_wr[i]) begin
                running = running + 1;
            end
        end
        n_writers = CW'(running);
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (lane_wr[i]) begin
                    buf_rd[lane_slot[i]]   <= in_rd[5*i +: 5];
                    buf_data[lane_slot[i]] <= lane_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= pop;
            if (pop) begin
                wr_reg  <= buf_rd[head];
                wr_data <= buf_data[head];
                head    <= PW'((int'(head) + 1) % DEPTH);
            end
            if (accept) begin
                tail <= PW'((int'(tail) + int'(n_writers)) % DEPTH);
            end
            count <= count + (accept ? n_writers : '0) - CW'(pop);
        end
    end

    always_comb begin
        logic [PW-1:0] slot;
        pending_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = PW'((int'(head) + k) % DEPTH);
            if (CW'(k) < count) begin
                pending_mask[buf_rd[slot]] = 1'b1;
            end
        end
        if (wr_en) begin
            pending_mask[wr_reg] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

`ifdef WB_FWD_EN
    // Scan oldest to youngest so the youngest buffered match overrides the write register.
    always_comb begin
        logic [PW-1:0] slot;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (wr_en && (wr_reg == fwd_rs)) begin
            fwd_hit  = 1'b1;
            fwd_data = wr_data;
        end
        for (int k = 0; k < DEPTH; k++) begin
            slot = PW'((int'(head) + k) % DEPTH);
            if ((CW'(k) < count) && (buf_rd[slot] == fwd_rs)) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data[slot];
            end
        end
        if (fwd_rs == 5'd0) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end
`else
    logic fwd_unused;
    assign fwd_unused = ^fwd_rs;
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
`endif

endmodule
